// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, horizontal/vertical raster counters and
// a registered colour/sync/data-enable output stage for a VGA pin interface.
// Optional build macro VGA_TEST_PATTERN_EN replaces rgb_in with internal
// 8-bar colour bars. If the macro is undefined, colour comes from rgb_in.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       line_start,
    output logic       frame_start,
    input  logic [7:0] rgb_in,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = 1'(SYNC_POL);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             pix_en_reg;
    logic [9:0]       hcount_reg, hcount_next;
    logic [9:0]       vcount_reg, vcount_next;
    logic [7:0]       rgb_reg;
    logic             hsync_reg, vsync_reg, de_reg;

    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [7:0]       pix_rgb;
    logic [7:0]       pix_blank;

    // Clock divider: pix_en is registered so it is a clean one-clock pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            pix_en_reg  <= 1'b0;
        end else begin
            pix_en_reg  <= (div_cnt_reg == DIV_LAST);
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        end
    end

    // Next raster position: advance one pixel, wrap line then frame.
    always_comb begin
        hcount_next = hcount_reg;
        vcount_next = vcount_reg;
        if (hcount_reg == H_LAST) begin
            hcount_next = '0;
            vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 10'd1;
        end else begin
            hcount_next = hcount_reg + 10'd1;
        end
    end

    // Raster counters move only on pixel ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else if (pix_en_reg) begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    // Region decode from the current coordinate.
    always_comb begin
        active = (hcount_reg < H_ACT) && (vcount_reg < V_ACT);
        hs_raw = (hcount_reg >= HS_FIRST) && (hcount_reg <= HS_LAST);
        vs_raw = (vcount_reg >= VS_FIRST) && (vcount_reg <= VS_LAST);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [9:0] BAR_W_L = 10'(BAR_W);

    logic [9:0] bar_idx;
    logic [2:0] bar;
    wire        unused_rgb_in = ^rgb_in;

    // Colour bars: bar index bits select full-scale r, g and b.
    always_comb begin
        bar_idx = hcount_reg / BAR_W_L;
        bar     = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
        pix_rgb = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
    end
`else
    // Colour comes straight from the pixel source for this coordinate.
    always_comb begin
        pix_rgb = rgb_in;
    end
`endif

    // Blank every colour bit outside the visible area.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blank
            assign pix_blank[gi] = pix_rgb[gi] & active;
        end
    endgenerate

    // Output stage: colour, sync and de all captured on the same pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg   <= '0;
            de_reg    <= 1'b0;
            hsync_reg <= ~SYNC_ON;
            vsync_reg <= ~SYNC_ON;
        end else if (pix_en_reg) begin
            rgb_reg   <= pix_blank;
            de_reg    <= active;
            hsync_reg <= hs_raw ? SYNC_ON : ~SYNC_ON;
            vsync_reg <= vs_raw ? SYNC_ON : ~SYNC_ON;
        end
    end

    assign pix_en      = pix_en_reg;
    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign line_start  = pix_en_reg && (hcount_reg == 10'd0);
    assign frame_start = pix_en_reg && (hcount_reg == 10'd0) && (vcount_reg == 10'd0);
    assign r           = rgb_reg[7:5];
    assign g           = rgb_reg[4:2];
    assign b           = rgb_reg[1:0];
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random rgb_in and random reset points, checked every clock
// against a model that derives the raster position arithmetically from the
// number of clocks since reset release.
module tb_vga_timing_gen;

    localparam int D  = 3;
    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rgb_in = 8'h00;
    logic       pix_en, line_start, frame_start, hsync, vsync, de;
    logic [9:0] hcount, vcount;
    logic [2:0] r, g;
    logic [1:0] b;

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: k = clock edges since reset release
    int k = 0;
    int m_hc = 0, m_vc = 0, m_en = 0;
    int e_r = 0, e_g = 0, e_b = 0, e_hs = 1, e_vs = 1, e_de = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // One clock: apply inputs, advance model on the edge, compare #1 later.
    task automatic clock_edge(input logic rst_v, input logic [7:0] rgb_v);
        int p, hc, vc, act;
        rst    = rst_v;
        rgb_in = rgb_v;
        @(posedge clk);
        if (rst_v) begin
            k = 0;
            e_r = 0; e_g = 0; e_b = 0; e_de = 0; e_hs = 1; e_vs = 1;
        end else begin
            if (k >= 1 && (k % D) == 0) begin
                p   = ((k - 1) / D) % FT;
                hc  = p % HT;
                vc  = p / HT;
                act = (hc < HA && vc < VA) ? 1 : 0;
                e_de = act;
`ifdef VGA_TEST_PATTERN_EN
                e_r = act ? (((hc / (HA / 8)) & 4) != 0 ? 7 : 0) : 0;
                e_g = act ? (((hc / (HA / 8)) & 2) != 0 ? 7 : 0) : 0;
                e_b = act ? (((hc / (HA / 8)) & 1) != 0 ? 3 : 0) : 0;
`else
                e_r = act ? int'(rgb_v) / 32 : 0;
                e_g = act ? (int'(rgb_v) / 4) % 8 : 0;
                e_b = act ? int'(rgb_v) % 4 : 0;
`endif
                e_hs = (hc >= HA + HF && hc < HA + HF + HS) ? 0 : 1;
                e_vs = (vc >= VA + VF && vc < VA + VF + VS) ? 0 : 1;
            end
            k++;
        end
        m_en = (k >= 1 && (k % D) == 0) ? 1 : 0;
        p    = (k >= 1) ? ((k - 1) / D) % FT : 0;
        m_hc = p % HT;
        m_vc = p / HT;
        #1;
        check_val("pix_en", 32'(pix_en), m_en);
        check_val("hcount", 32'(hcount), m_hc);
        check_val("vcount", 32'(vcount), m_vc);
        check_val("line_start", 32'(line_start), (m_en != 0 && m_hc == 0) ? 1 : 0);
        check_val("frame_start", 32'(frame_start), (m_en != 0 && m_hc == 0 && m_vc == 0) ? 1 : 0);
        check_val("r", 32'(r), e_r);
        check_val("g", 32'(g), e_g);
        check_val("b", 32'(b), e_b);
        check_val("hsync", 32'(hsync), e_hs);
        check_val("vsync", 32'(vsync), e_vs);
        check_val("de", 32'(de), e_de);
        if (!rst_v && m_en != 0 && m_hc == 0)
            $display("line vcount=%0d k=%0d checks=%0d errors=%0d", m_vc, k, checks, errors);
    endtask

    function automatic logic [7:0] rand_rgb();
        return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    endfunction

    initial begin
        // reset held: everything at reset values
        for (int i = 0; i < 3; i++) clock_edge(1'b1, rand_rgb());
        $display("reset released");

        // two full frames plus a margin of free run
        for (int i = 0; i < 2 * FT * D + 50; i++) clock_edge(1'b0, rand_rgb());

        // run to a chosen mid-frame coordinate, then a one-clock reset
        begin : seek
            int n;
            n = 0;
            while (!(m_en != 0 && m_hc == 20 && m_vc == 5) && n < FT * D + 10) begin
                clock_edge(1'b0, rand_rgb());
                n++;
            end
            check_val("seek_timeout", (n < FT * D + 10) ? 1 : 0, 1);
        end
        clock_edge(1'b1, rand_rgb());
        $display("mid-frame reset at hcount=20 vcount=5");

        // random reset points
        for (int j = 0; j < 3; j++) begin
            int len;
            len = $urandom_range(1, FT * D);
            for (int i = 0; i < len; i++) clock_edge(1'b0, rand_rgb());
            clock_edge(1'b1, rand_rgb());
            $display("random reset after %0d clocks", len);
        end

        // final full frame after the last reset
        for (int i = 0; i < FT * D + 20; i++) clock_edge(1'b0, rand_rgb());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
